adc_accum_sequencer: RTL and testbench
======================================

ADC_ACCUM_SEQUENCER -- requirements
Module: adc_accum_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ADC, default 3: number of daisy-chained 18-bit ADCs per conversion word.
REQ-002 The block SHALL have parameter ACC_W, default 26: accumulator and output width; values below 26 are illegal.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 num_samples  input  8  burst length minus one (0 = 1 conversion, 255 = 256); latched on accepted start.
REQ-007 adc_trigger  output  1  conversion request to the ADC daisy-chain controller.
REQ-008 adc_ready  input  1  ADC controller holds conversion word valid.
REQ-009 adc_dout  input  18*NUM_ADC  conversion word; channel k = bits [18k+17:18k], unsigned.
REQ-010 adc_ack  output  1  releases the ADC controller back to its idle state.
REQ-011 out_valid  output  1  out_data/out_chan hold a result.
REQ-012 out_ready  input  1  downstream accepts the result when high with out_valid.
REQ-013 out_data  output  ACC_W  per-channel sum over the burst, zero-extended.
REQ-014 out_chan  output  8  channel index of out_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last channel is transferred.

Function
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT, ACK, OUT; all outputs are decoded from state/registers only.
REQ-018 IDLE: start=1 -> clear all NUM_ADC accumulators, clear sample_cnt, latch num_samples, go TRIG; start=0 -> stay.
REQ-019 TRIG: adc_trigger=1 for exactly one cycle, then go WAIT unconditionally.
REQ-020 WAIT: adc_trigger=0; on adc_ready=1, add each adc_dout channel to its accumulator once, increment sample_cnt, go ACK; otherwise stay, with no timeout.
REQ-021 ACK: adc_ack=1 for exactly one cycle; then go OUT if sample_cnt == latched num_samples+1, else TRIG.
REQ-022 Accumulation SHALL be performed only on the WAIT->ACK edge, so a word held ready across several cycles is counted once.
REQ-023 Accumulator arithmetic SHALL be unsigned ACC_W-bit; with ACC_W>=26 no overflow is possible (256*(2^18-1) < 2^26).
REQ-024 OUT: out_valid=1, out_chan=ch, out_data=acc[ch], starting at ch=0; on out_valid&&out_ready, advance ch.
REQ-025 While out_ready=0, out_data and out_chan SHALL stay stable.
REQ-026 On the transfer of ch=NUM_ADC-1: done=1 in the next cycle, state=IDLE, out_valid=0.
REQ-027 start SHALL be ignored in every state except IDLE; a start in the done cycle is accepted.
REQ-028 adc_ready asserted outside WAIT SHALL be ignored.
REQ-029 Latency: start at cycle 0 -> adc_trigger high at cycle 1.

Reset
REQ-030 On rst, in any state: state=IDLE; adc_trigger, adc_ack, out_valid, busy, done=0; out_data=0, out_chan=0; accumulators, sample_cnt and ch=0.
REQ-031 An interrupted burst SHALL be discarded, with no done; the ADC controller shares rst, so no ack is owed.

Verification
REQ-032 NUM_ADC=3, num_samples=0, adc_dout={18'd3,18'd2,18'd1} -> one trigger, one ack; outputs chan0=1, chan1=2, chan2=3; done once.
REQ-033 num_samples=255, every channel 18'h3FFFF each conversion -> 256 triggers/acks; each out_data = 26'h3FFFF00.
REQ-034 adc_ready held high 5 cycles in WAIT -> accumulator incremented once and adc_ack a single pulse.
REQ-035 out_ready low for 10 cycles in OUT -> out_valid, out_data, out_chan stable; then 3 back-to-back transfers on consecutive cycles.
REQ-036 rst pulsed in WAIT after 2 of 4 conversions -> all outputs 0 at once; a new start then yields sums of fresh data only.
REQ-037 start pulsed during WAIT and OUT -> no effect on the burst; start pulsed in the done cycle -> adc_trigger high in the next cycle.

Source files
------------

// File: rtl/adc_accum_sequencer.sv
// Burst sequencer for a daisy-chain of 18-bit ADCs: triggers num_samples+1
// conversions, accumulates each channel, then streams the per-channel sums out.
//
// state | meaning
// IDLE  | waiting for start
// TRIG  | one-cycle conversion request to the ADC controller
// WAIT  | waiting for the conversion word (adc_ready), no timeout
// ACK   | one-cycle release of the ADC controller
// OUT   | presenting acc[ch] until the last channel is accepted
module adc_accum_sequencer #(
  parameter int NUM_ADC = 3,
  parameter int ACC_W   = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             num_samples,
  output logic                   adc_trigger,
  input  logic                   adc_ready,
  input  logic [18*NUM_ADC-1:0]  adc_dout,
  output logic                   adc_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [7:0]             out_chan,
  output logic                   busy,
  output logic                   done
);

  localparam int CH_W = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, ACK, OUT} state_t;

  state_t          state;
  logic [ACC_W-1:0] acc [NUM_ADC];
  logic [8:0]      sample_cnt;
  logic [7:0]      num_lat;
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] ch_nxt;
  logic            last_sample;
  logic            last_ch;

  assign ch_nxt      = ch + CH_W'(1);
  assign last_sample = (sample_cnt == ({1'b0, num_lat} + 9'd1));
  assign last_ch     = (ch == CH_W'(NUM_ADC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      adc_trigger <= 1'b0;
      adc_ack     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_data    <= '0;
      out_chan    <= '0;
      sample_cnt  <= '0;
      num_lat     <= '0;
      ch          <= '0;
      for (int k = 0; k < NUM_ADC; k++) acc[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_ADC; k++) acc[k] <= '0;
            sample_cnt  <= '0;
            num_lat     <= num_samples;
            ch          <= '0;
            busy        <= 1'b1;
            adc_trigger <= 1'b1;
            state       <= TRIG;
          end
        end
        TRIG: begin
          adc_trigger <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          // Leaving WAIT immediately guarantees a held word is summed once.
          if (adc_ready) begin
            for (int k = 0; k < NUM_ADC; k++)
              acc[k] <= acc[k] + ACC_W'(adc_dout[18*k +: 18]);
            sample_cnt <= sample_cnt + 9'd1;
            adc_ack    <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          adc_ack <= 1'b0;
          if (last_sample) begin
            out_valid <= 1'b1;
            out_data  <= acc[0];
            out_chan  <= '0;
            ch        <= '0;
            state     <= OUT;
          end else begin
            adc_trigger <= 1'b1;
            state       <= TRIG;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (last_ch) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              ch       <= ch_nxt;
              out_data <= acc[ch_nxt];
              out_chan <= 8'(ch_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_accum_sequencer.sv
// Directed bench for adc_accum_sequencer: expected channel sums are queued when
// a burst is issued and a monitor pops/compares each accepted output.
module tb_adc_accum_sequencer;

  localparam int NUM_ADC = 3;
  localparam int ACC_W   = 26;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [7:0]            num_samples = '0;
  logic                  adc_trigger;
  logic                  adc_ready = 1'b0;
  logic [18*NUM_ADC-1:0] adc_dout = '0;
  logic                  adc_ack;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [ACC_W-1:0]      out_data;
  logic [7:0]            out_chan;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int ack_cnt = 0;
  logic [33:0] exp_q [$];

  adc_accum_sequencer #(.NUM_ADC(NUM_ADC), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .adc_trigger(adc_trigger), .adc_ready(adc_ready), .adc_dout(adc_dout),
    .adc_ack(adc_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (adc_trigger === 1'b1) trig_cnt++;
    if (adc_ack === 1'b1) ack_cnt++;
  end

  // Scoreboard monitor: every accepted output must match the head of the queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got chan %0d data %0h, expected nothing", out_chan, out_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("out_chan", 64'(out_chan), 64'(e[33:26]));
        chk("out_data", 64'(out_data), 64'(e[25:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sel 0 waits for adc_trigger, sel 1 for out_valid; bounded to 100 cycles.
  task automatic wait_sig(input int sel, input string name);
    int n = 0;
    while (!((sel == 0) ? adc_trigger : out_valid) && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    chk(name, 64'((sel == 0) ? adc_trigger : out_valid), 64'd1);
  endtask

  task automatic do_start(input int n);
    num_samples = 8'(n);
    trig_cnt = 0;
    ack_cnt = 0;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    chk("start_latency_trigger", 64'(adc_trigger), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic adc_conv(input logic [53:0] w, input int lat, input int hold, input bit poke);
    wait_sig(0, "wait_trigger");
    adc_dout = w;
    @(posedge clk) #1;
    if (poke) begin
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
    end
    repeat (lat) @(posedge clk) #1;
    adc_ready = 1'b1;
    repeat (hold) @(posedge clk) #1;
    adc_ready = 1'b0;
  endtask

  task automatic body(input int n, input logic [53:0] w, input int lat, input int hold,
                      input bit poke, input int stall,
                      input logic [25:0] e0, input logic [25:0] e1, input logic [25:0] e2,
                      input bit chain);
    exp_q.push_back({8'd0, e0});
    exp_q.push_back({8'd1, e1});
    exp_q.push_back({8'd2, e2});
    for (int i = 0; i <= n; i++) adc_conv(w, lat, hold, poke && i == 0);
    wait_sig(1, "wait_out_valid");
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(e0));
      chk("stall_chan", 64'(out_chan), 64'd0);
      start = (poke && i == 3);
      @(posedge clk) #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (NUM_ADC) @(posedge clk) #1;
    out_ready = 1'b0;
    chk("done_after_last", 64'(done), 64'd1);
    chk("valid_after_last", 64'(out_valid), 64'd0);
    chk("busy_after_last", 64'(busy), 64'd0);
    chk("trigger_count", 64'(trig_cnt), 64'(n + 1));
    chk("ack_count", 64'(ack_cnt), 64'(n + 1));
    if (chain) begin
      trig_cnt = 0;
      ack_cnt = 0;
      start = 1'b1;
    end
    @(posedge clk) #1;
    start = 1'b0;
    chk("done_pulse_width", 64'(done), 64'd0);
    if (chain) chk("done_cycle_start_trigger", 64'(adc_trigger), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", 64'(adc_trigger), 64'd0);
    chk("rst_ack", 64'(adc_ack), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_chan", 64'(out_chan), 64'd0);
    rst = 1'b0;
    @(posedge clk) #1;

    // Single conversion, channels 1/2/3.
    do_start(0);
    body(0, {18'd3, 18'd2, 18'd1}, 1, 1, 1'b0, 0, 26'd1, 26'd2, 26'd3, 1'b0);

    // adc_ready held for 5 cycles: summed once, single ack.
    do_start(0);
    body(0, {18'd7, 18'd5, 18'd9}, 0, 5, 1'b0, 0, 26'd9, 26'd5, 26'd7, 1'b0);

    // Two conversions, start poked in WAIT and OUT, 10-cycle stall, then a
    // start in the done cycle launches a 3-conversion burst.
    do_start(1);
    num_samples = 8'd2;
    body(1, {18'd100, 18'd200, 18'd300}, 2, 1, 1'b1, 10, 26'd600, 26'd400, 26'd200, 1'b1);
    body(2, {18'd1, 18'd1, 18'd1}, 3, 1, 1'b0, 0, 26'd3, 26'd3, 26'd3, 1'b0);

    // Full-scale 256-conversion burst.
    do_start(255);
    body(255, {3{18'h3FFFF}}, 0, 1, 1'b0, 0, 26'h3FFFF00, 26'h3FFFF00, 26'h3FFFF00, 1'b0);

    // Reset in WAIT of the third of four conversions, then a fresh burst.
    do_start(3);
    adc_conv({18'd50, 18'd60, 18'd70}, 0, 1, 1'b0);
    adc_conv({18'd50, 18'd60, 18'd70}, 0, 1, 1'b0);
    wait_sig(0, "wait_trigger_before_rst");
    @(posedge clk) #1;
    rst = 1'b1;
    #1;
    chk("midrst_trigger", 64'(adc_trigger), 64'd0);
    chk("midrst_ack", 64'(adc_ack), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_chan", 64'(out_chan), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk) #1;
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_done", 64'(done), 64'd0);
    do_start(3);
    body(3, {18'd4, 18'd5, 18'd6}, 1, 1, 1'b0, 0, 26'd24, 26'd20, 26'd16, 1'b0);

    repeat (3) @(posedge clk) #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
